seq_alu_exec: RTL and testbench
===============================

SEQ_ALU_EXEC -- requirements
Module: seq_alu_exec

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with the ports listed below.
REQ-002 CLK  input  1  clock; all state changes on the rising edge.
REQ-003 Reset  input  1  synchronous active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled only while ready=1.
REQ-005 ALUCtrl  input  4  operation code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PASSB.
REQ-006 BusA  input  64  operand A; captured at accept.
REQ-007 BusB  input  64  operand B; captured at accept.
REQ-008 ready  output  1  high only in IDLE; the block can accept start.
REQ-009 done  output  1  one-cycle pulse; BusW, Zero and err are valid.
REQ-010 BusW  output  64  result.
REQ-011 Zero  output  1  high when the result is all zeros (used by CBZ).
REQ-012 err  output  1  high with done when ALUCtrl was not a legal code.

Function
REQ-013 The FSM SHALL have three states: IDLE, EXEC, DONE.
REQ-014 Accept: IDLE and start=1 at an edge -> latch ALUCtrl, BusA and BusB; clear slice index to 0; clear carry; enter EXEC.
REQ-015 EXEC: each edge computes one 16-bit slice [16i+15:16i], i=0..3, LSB first, into an internal result register.
REQ-016 After slice 3 the FSM SHALL enter DONE; done=1 for exactly that cycle, then IDLE on the next edge.
REQ-017 Latency: done is high in the 5th cycle after the accept edge; ready returns 1 one cycle later; throughput is 1 op per 6 cycles.
REQ-018 start while EXEC or DONE SHALL be ignored, and no state is altered.
REQ-019 Operand or ALUCtrl changes after accept SHALL NOT affect the operation in flight.
REQ-020 ADD: carry-in 0 into slice 0; each slice carry-out is registered and feeds the next slice.
REQ-021 SUB: A + ~B with carry-in 1 into slice 0; carry chained as for ADD.
REQ-022 Arithmetic wraps mod 2^64; final carry-out and overflow are discarded.
REQ-023 AND/OR: bitwise per slice; carry unused.
REQ-024 PASSB: BusW = B.
REQ-025 Zero = (BusW == 0), updated at the DONE transition.
REQ-026 Illegal ALUCtrl: full 4-cycle EXEC still runs; BusW=0, Zero=0, err=1 at done.
REQ-027 BusW, Zero and err SHALL hold their values from done until the next done or reset; err clears at the next accept.

Reset
REQ-028 Reset=1 at an edge SHALL force IDLE, ready=1, done=0, BusW=0, Zero=0, err=0, carry=0 and slice index=0.
REQ-029 Reset SHALL take priority over start and abort any operation in flight; no done is produced for an aborted operation.
REQ-030 start asserted in the same cycle as Reset SHALL be ignored.

Structure
REQ-031 Shared package alu_pkg SHALL hold: the ALUCtrl code constants (same encodings as the ALU control decoder), SLICE_W=16, NUM_SLICES=4, DATA_W=64 and the FSM state encoding.
REQ-032 There SHALL be one sub-module, alu_slice16: combinational 16-bit AND/OR/ADD/SUB/PASSB with carry-in and carry-out, instantiated once and reused every cycle.

Verification
REQ-033 ADD carry chain: A=64'h0000_0000_0000_FFFF, B=1, ALUCtrl=0010 -> done 5 cycles after accept; BusW=64'h0000_0000_0001_0000; Zero=0; err=0.
REQ-034 SUB to zero with full borrow chain: A=B=64'h8000_0000_0000_0001, ALUCtrl=0110 -> BusW=0, Zero=1; then A=0, B=1 -> BusW=64'hFFFF_FFFF_FFFF_FFFF, Zero=0.
REQ-035 CBZ and illegal code: ALUCtrl=0111, B=0 -> BusW=0, Zero=1; then ALUCtrl=1111 -> BusW=0, Zero=0, err=1, done still at cycle 5.
REQ-036 Busy/operand stability: accept AND with A=64'hF0F0..F0, B=64'hFF00..FF00; pulse start and change A, B and ALUCtrl during EXEC -> ignored; BusW=64'hF000_F000_F000_F000; exactly one done pulse.
REQ-037 Reset mid-operation: assert Reset at slice 2 of an ADD -> next cycle ready=1, BusW=0, done never pulses; a fresh OR of 64'h1 | 64'h2 then gives BusW=3.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential 64-bit ALU: operation codes, widths
// and the controller state encoding.
package alu_pkg;

  localparam int DATA_W     = 64;
  localparam int SLICE_W    = 16;
  localparam int NUM_SLICES = 4;
  localparam int IDX_W      = 2;

  // Operation codes, matching the ALU control decoder
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for the five supported operation codes
  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASSB: is_legal = 1'b1;
      default:                                      is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_slice16.sv
// Combinational 16-bit ALU slice. Carry-in and carry-out let the top chain
// four slices over consecutive cycles. SUB is A + ~B + cin; the caller
// supplies cin=1 for the lowest slice.
module alu_slice16
  import alu_pkg::*;
(
  input  logic [3:0]         op,
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] y,
  output logic               cout
);

  logic [SLICE_W:0] sum;

  // Select the slice result; carry-out is only meaningful for ADD/SUB
  always_comb begin
    sum  = '0;
    y    = '0;
    cout = 1'b0;
    case (op)
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_ADD: begin
        sum  = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
        y    = sum[SLICE_W-1:0];
        cout = sum[SLICE_W];
      end
      ALU_SUB: begin
        sum  = {1'b0, a} + {1'b0, ~b} + {{SLICE_W{1'b0}}, cin};
        y    = sum[SLICE_W-1:0];
        cout = sum[SLICE_W];
      end
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/seq_alu_exec.sv
// Sequential 64-bit ALU: one 16-bit slice per cycle, LSB first, using a
// single shared slice. Operands and opcode are latched at accept, so the
// inputs may change freely while the operation runs.
//
// Handshake: start is sampled only while ready=1; an edge with ready=1 and
// start=1 is the accept. done pulses for one cycle exactly five cycles
// later, and BusW/Zero/err hold from that pulse until the next one.
module seq_alu_exec
  import alu_pkg::*;
(
  input  logic              CLK,
  input  logic              Reset,
  input  logic              start,
  input  logic [3:0]        ALUCtrl,
  input  logic [DATA_W-1:0] BusA,
  input  logic [DATA_W-1:0] BusB,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] BusW,
  output logic              Zero,
  output logic              err,
  output state_t            dbg_state
);

  state_t              state;
  logic [3:0]          op_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   res_q;
  logic [IDX_W-1:0]    idx;
  logic                carry;

  logic [5:0]          lsb;
  logic                slice_cin;
  logic [SLICE_W-1:0]  slice_y;
  logic                slice_cout;
  logic                last_slice;
  logic                legal;
  logic [DATA_W-1:0]   final_res;

  assign lsb        = {idx, 4'b0000};
  assign last_slice = (idx == IDX_W'(NUM_SLICES - 1));
  assign legal      = is_legal(op_q);
  assign final_res  = {slice_y, res_q[DATA_W-SLICE_W-1:0]};
  assign dbg_state  = state;

  // Slice 0 takes the fixed carry-in (1 for SUB); later slices take the
  // registered carry from the previous slice
  assign slice_cin = (idx == '0) ? (op_q == ALU_SUB) : carry;

  alu_slice16 u_slice (
    .op   (op_q),
    .a    (a_q[lsb +: SLICE_W]),
    .b    (b_q[lsb +: SLICE_W]),
    .cin  (slice_cin),
    .y    (slice_y),
    .cout (slice_cout)
  );

  // Controller FSM with registered handshake and result outputs
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= ST_IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      BusW  <= '0;
      Zero  <= 1'b0;
      err   <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= ALUCtrl;
            a_q   <= BusA;
            b_q   <= BusB;
            idx   <= '0;
            carry <= 1'b0;
            err   <= 1'b0;
            ready <= 1'b0;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q[lsb +: SLICE_W] <= slice_y;
          carry <= slice_cout;
          idx   <= idx + 1'b1;
          if (last_slice) begin
            state <= ST_DONE;
            done  <= 1'b1;
            BusW  <= legal ? final_res : '0;
            Zero  <= legal && (final_res == '0);
            err   <= !legal;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_exec.sv
// Bench for seq_alu_exec: directed operations with literal expectations,
// plus a cycle-level reference model compared against the outputs every cycle.
module tb_seq_alu_exec;
  import alu_pkg::*;

  logic              CLK;
  logic              Reset;
  logic              start;
  logic [3:0]        ALUCtrl;
  logic [63:0]       BusA;
  logic [63:0]       BusB;
  logic              ready;
  logic              done;
  logic [63:0]       BusW;
  logic              Zero;
  logic              err;
  state_t            dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  seq_alu_exec dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .start     (start),
    .ALUCtrl   (ALUCtrl),
    .BusA      (BusA),
    .BusB      (BusB),
    .ready     (ready),
    .done      (done),
    .BusW      (BusW),
    .Zero      (Zero),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {err, zero, busw} from plain 64-bit arithmetic
  function automatic logic [65:0] alu_model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    logic        ok;
    ok = 1'b1;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = b;
      default: begin r = 64'd0; ok = 1'b0; end
    endcase
    alu_model = {!ok, ok && (r == 64'd0), r};
  endfunction

  // Scoreboard: expected results queued at accept, retired at done
  logic [65:0] exp_q[$];
  int          m_cnt   = 0;      // cycles since accept, 0 when idle
  logic        m_valid = 1'b0;
  logic [63:0] m_w     = '0;
  logic        m_z     = 1'b0;
  logic        m_e     = 1'b0;

  // Model: advance on each rising edge using the inputs held across it
  always @(posedge CLK) begin
    logic [65:0] e;
    if (Reset) begin
      m_cnt = 0;
      exp_q.delete();
      m_w = '0; m_z = 1'b0; m_e = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_cnt == 0) begin
        if (start) begin
          m_cnt = 1;
          m_e   = 1'b0;
          exp_q.push_back(alu_model(ALUCtrl, BusA, BusB));
        end
      end else begin
        m_cnt = (m_cnt == 5) ? 0 : m_cnt + 1;
        if (m_cnt == 5) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m_e = e[65]; m_z = e[64]; m_w = e[63:0];
          end
        end
      end
    end
  end

  // Compare: check every output on the falling edge once reset has been seen
  always @(negedge CLK) begin
    if (done === 1'b1) done_cnt++;
    if (m_valid) begin
      chk("cyc_ready", {63'd0, ready}, {63'd0, m_cnt == 0});
      chk("cyc_done",  {63'd0, done},  {63'd0, m_cnt == 5});
      chk("cyc_busw",  BusW, m_w);
      chk("cyc_zero",  {63'd0, Zero}, {63'd0, m_z});
      chk("cyc_err",   {63'd0, err},  {63'd0, m_e});
    end
  end

  // Driver: issue one operation and check its literal expected result and latency
  task automatic run_op(input string name, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] ew, input logic ez, input logic ee);
    int cyc;
    @(negedge CLK);
    ALUCtrl = op; BusA = a; BusB = b; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge CLK);
      cyc++;
    end
    chk({name, "_latency"}, 64'(cyc), 64'd5);
    chk({name, "_busw"}, BusW, ew);
    chk({name, "_zero"}, {63'd0, Zero}, {63'd0, ez});
    chk({name, "_err"},  {63'd0, err},  {63'd0, ee});
    @(negedge CLK);
    chk({name, "_ready_after"}, {63'd0, ready}, 64'd1);
  endtask

  initial begin
    int cyc;
    int d0;
    Reset = 1'b1; start = 1'b0; ALUCtrl = '0; BusA = '0; BusB = '0;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_done",  {63'd0, done},  64'd0);
    chk("rst_busw",  BusW, 64'd0);
    chk("rst_zero",  {63'd0, Zero}, 64'd0);
    chk("rst_err",   {63'd0, err},  64'd0);

    run_op("add_carry", 4'b0010, 64'h0000_0000_0000_FFFF, 64'd1, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    run_op("add_wrap",  4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0);
    run_op("sub_zero",  4'b0110, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 64'd0, 1'b1, 1'b0);
    run_op("sub_borrow",4'b0110, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_op("passb_cbz", 4'b0111, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'd0, 1'b1, 1'b0);
    run_op("illegal",   4'b1111, 64'h1234, 64'h5678, 64'd0, 1'b0, 1'b1);
    run_op("or_basic",  4'b0001, 64'h00FF_0000_0000_0F00, 64'h0F00_0000_0000_00F0, 64'h0FFF_0000_0000_0FF0, 1'b0, 1'b0);

    // AND with start pulses and operand churn while busy
    @(negedge CLK);
    d0 = done_cnt;
    ALUCtrl = 4'b0000; BusA = 64'hF0F0_F0F0_F0F0_F0F0; BusB = 64'hFF00_FF00_FF00_FF00; start = 1'b1;
    @(negedge CLK);
    cyc = 1;
    ALUCtrl = 4'b0001; BusA = '1; BusB = '1;
    repeat (2) begin
      @(negedge CLK); cyc++;
      ALUCtrl = 4'b0010; BusA = 64'd7; BusB = 64'd9;
    end
    start = 1'b0;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge CLK); cyc++;
    end
    chk("busy_latency", 64'(cyc), 64'd5);
    chk("busy_busw", BusW, 64'hF000_F000_F000_F000);
    repeat (3) @(negedge CLK);
    chk("busy_one_done", 64'(done_cnt - d0), 64'd1);

    // Reset during slice 2 of an ADD aborts it without a done pulse
    @(negedge CLK);
    d0 = done_cnt;
    ALUCtrl = 4'b0010; BusA = 64'h1111; BusB = 64'h2222; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    chk("abort_ready", {63'd0, ready}, 64'd1);
    chk("abort_busw",  BusW, 64'd0);
    repeat (8) @(negedge CLK);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    run_op("or_fresh", 4'b0001, 64'h1, 64'h2, 64'h3, 1'b0, 1'b0);

    // start held together with Reset is ignored
    d0 = done_cnt;
    Reset = 1'b1; start = 1'b1;
    @(negedge CLK);
    Reset = 1'b0; start = 1'b0;
    @(negedge CLK);
    chk("rst_start_ready", {63'd0, ready}, 64'd1);
    repeat (6) @(negedge CLK);
    chk("rst_start_no_done", 64'(done_cnt - d0), 64'd0);

    run_op("sub_mid", 4'b0110, 64'h0001_0000_0000_0000, 64'd1, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
